// File: rtl/motor_driver.sv
// Two-wheel H-bridge driver. It latches a 3-bit motion command once per PWM
// period and ramps each wheel's duty toward that command's target. A wheel
// reverses only after it has ramped to zero and coasted for DEAD_PERIODS
// whole PWM periods. Direction pins and PWM enables are registered outputs.
module motor_driver #(
  parameter int PWM_BITS     = 10,
  parameter int FULL_DUTY    = 1023,
  parameter int TURN_DUTY    = 512,
  parameter int SPIN_DUTY    = 768,
  parameter int RAMP_STEP    = 64,
  parameter int DEAD_PERIODS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          state,
  output logic [1:0]          left_motor,
  output logic [1:0]          right_motor,
  output logic                left_pwm,
  output logic                right_pwm,
  output logic [PWM_BITS-1:0] left_duty,
  output logic [PWM_BITS-1:0] right_duty
);

  localparam int DW  = PWM_BITS + 1;
  localparam int DCW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

  localparam logic [2:0] CMD_STOP         = 3'd0;
  localparam logic [2:0] CMD_FORWARD      = 3'd1;
  localparam logic [2:0] CMD_BACK         = 3'd2;
  localparam logic [2:0] CMD_LEFT         = 3'd3;
  localparam logic [2:0] CMD_RIGHT        = 3'd4;
  localparam logic [2:0] CMD_STRONG_LEFT  = 3'd5;
  localparam logic [2:0] CMD_STRONG_RIGHT = 3'd6;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  localparam logic [PWM_BITS-1:0] FULL_D = PWM_BITS'(FULL_DUTY);
  localparam logic [PWM_BITS-1:0] TURN_D = PWM_BITS'(TURN_DUTY);
  localparam logic [PWM_BITS-1:0] SPIN_D = PWM_BITS'(SPIN_DUTY);
  localparam logic [DW-1:0]       STEP_W = DW'(RAMP_STEP);
  localparam logic [DCW-1:0]      DEAD_LAST = DCW'(DEAD_PERIODS - 1);

  typedef enum logic [1:0] {
    W_RUN       = 2'd0,
    W_RAMP_DOWN = 2'd1,
    W_DEAD      = 2'd2
  } wheel_st_e;

  typedef struct packed {
    wheel_st_e           st;
    logic                dir;
    logic [PWM_BITS-1:0] duty;
    logic [DCW-1:0]      dead_cnt;
  } wheel_t;

  localparam wheel_t WHEEL_RST = '{st: W_RUN, dir: DIR_FWD, duty: '0, dead_cnt: '0};

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [2:0]          cmd_q, cmd_d;
  wheel_t              wheel_l_q, wheel_l_d, wheel_r_q, wheel_r_d;
  logic [1:0]          motor_l_q, motor_l_d, motor_r_q, motor_r_d;
  logic                pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
  logic                wrap;
  logic                tgt_dir_l, tgt_dir_r;
  logic [PWM_BITS-1:0] tgt_duty_l, tgt_duty_r;

  // One wrap's worth of wheel FSM: ramp, soft stop before reversal, dead-time coast.
  function automatic wheel_t wheel_step(input wheel_t cur, input logic tgt_dir,
                                        input logic [PWM_BITS-1:0] tgt_duty);
    wheel_t        nxt;
    logic [DW-1:0] duty_w, tgt_w, up, dn;
    nxt    = cur;
    duty_w = {1'b0, cur.duty};
    tgt_w  = {1'b0, tgt_duty};
    up     = duty_w + STEP_W;
    dn     = (duty_w >= STEP_W) ? (duty_w - STEP_W) : '0;
    case (cur.st)
      W_RUN: begin
        if (tgt_dir != cur.dir) begin
          // A loaded wheel must ramp down first; an idle one goes straight to coast.
          if (cur.duty != '0) begin
            nxt.st = W_RAMP_DOWN;
          end else begin
            nxt.st       = W_DEAD;
            nxt.dead_cnt = '0;
          end
        end else if (duty_w < tgt_w) begin
          nxt.duty = (up > tgt_w) ? tgt_duty : up[PWM_BITS-1:0];
        end else if (duty_w > tgt_w) begin
          nxt.duty = (dn < tgt_w) ? tgt_duty : dn[PWM_BITS-1:0];
        end
      end
      W_RAMP_DOWN: begin
        if (tgt_dir == cur.dir) begin
          nxt.st = W_RUN;
        end else begin
          nxt.duty = dn[PWM_BITS-1:0];
          if (dn == '0) begin
            nxt.st       = W_DEAD;
            nxt.dead_cnt = '0;
          end
        end
      end
      W_DEAD: begin
        nxt.duty = '0;
        // The direction is only committed on exit, so edits made while coasting are harmless.
        if (cur.dead_cnt == DEAD_LAST) begin
          nxt.dir      = tgt_dir;
          nxt.st       = W_RUN;
          nxt.dead_cnt = '0;
        end else begin
          nxt.dead_cnt = cur.dead_cnt + DCW'(1);
        end
      end
      default: begin
        nxt.st   = W_RUN;
        nxt.duty = '0;
      end
    endcase
    return nxt;
  endfunction

  // Pin encoding: coast whenever the wheel is unpowered or in dead time; never 2'b11.
  function automatic logic [1:0] motor_enc(input wheel_t w);
    if (w.st == W_DEAD || w.duty == '0) return 2'b00;
    return (w.dir == DIR_REV) ? 2'b01 : 2'b10;
  endfunction

  // Per-wheel targets from the latched command; STOP keeps the present direction.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    tgt_dir_l  = wheel_l_q.dir;
    tgt_dir_r  = wheel_r_q.dir;
    tgt_duty_l = '0;
    tgt_duty_r = '0;
    case (cmd_q)
      CMD_STOP: ;
      CMD_FORWARD:      begin tgt_dir_l = DIR_FWD; tgt_duty_l = FULL_D; tgt_dir_r = DIR_FWD; tgt_duty_r = FULL_D; end
      CMD_BACK:         begin tgt_dir_l = DIR_REV; tgt_duty_l = FULL_D; tgt_dir_r = DIR_REV; tgt_duty_r = FULL_D; end
      CMD_LEFT:         begin tgt_dir_l = DIR_FWD; tgt_duty_l = TURN_D; tgt_dir_r = DIR_FWD; tgt_duty_r = FULL_D; end
      CMD_RIGHT:        begin tgt_dir_l = DIR_FWD; tgt_duty_l = FULL_D; tgt_dir_r = DIR_FWD; tgt_duty_r = TURN_D; end
      CMD_STRONG_LEFT:  begin tgt_dir_l = DIR_REV; tgt_duty_l = SPIN_D; tgt_dir_r = DIR_FWD; tgt_duty_r = SPIN_D; end
      CMD_STRONG_RIGHT: begin tgt_dir_l = DIR_FWD; tgt_duty_l = SPIN_D; tgt_dir_r = DIR_REV; tgt_duty_r = SPIN_D; end
      default: ;
    endcase
  end

  // Next state: counter free-runs; command and wheels move only at the period wrap.
  always_comb begin
    wrap      = (pwm_cnt_q == '1);
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    cmd_d     = cmd_q;
    wheel_l_d = wheel_l_q;
    wheel_r_d = wheel_r_q;
    if (wrap) begin
      cmd_d     = state;
      wheel_l_d = wheel_step(wheel_l_q, tgt_dir_l, tgt_duty_l);
      wheel_r_d = wheel_step(wheel_r_q, tgt_dir_r, tgt_duty_r);
    end
    // Outputs are computed from next-state values so the registered pins line up with pwm_cnt.
    pwm_l_d   = (pwm_cnt_d < wheel_l_d.duty);
    pwm_r_d   = (pwm_cnt_d < wheel_r_d.duty);
    motor_l_d = motor_enc(wheel_l_d);
    motor_r_d = motor_enc(wheel_r_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      pwm_cnt_q <= '0;
      cmd_q     <= CMD_STOP;
      wheel_l_q <= WHEEL_RST;
      wheel_r_q <= WHEEL_RST;
      motor_l_q <= 2'b00;
      motor_r_q <= 2'b00;
      pwm_l_q   <= 1'b0;
      pwm_r_q   <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      cmd_q     <= cmd_d;
      wheel_l_q <= wheel_l_d;
      wheel_r_q <= wheel_r_d;
      motor_l_q <= motor_l_d;
      motor_r_q <= motor_r_d;
      pwm_l_q   <= pwm_l_d;
      pwm_r_q   <= pwm_r_d;
    end
  end

  assign left_motor  = motor_l_q;
  assign right_motor = motor_r_q;
  assign left_pwm    = pwm_l_q;
  assign right_pwm   = pwm_r_q;
  assign left_duty   = wheel_l_q.duty;
  assign right_duty  = wheel_r_q.duty;

endmodule
